// File: rtl/project2_pkg.sv
// project2 shared constants: seven-segment table and key roles.
// Segment codes are active-low, bit6..bit0 = g,f,e,d,c,b,a.
package project2_pkg;

    localparam int KEY_ADD   = 0;
    localparam int KEY_SUB   = 1;
    localparam int KEY_DIGIT = 2;
    localparam int KEY_CLR   = 3;

    localparam int NDIG = 6;

    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/project2_if.sv
// project2_if: board pin bundle (switches, buttons, LEDs, digits).
// master = board/stimulus side, slave = calculator side.
interface project2_if;

    logic [9:0] SW;
    logic [3:0] KEY;
    logic [9:0] LEDR;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output SW, KEY,
        input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  SW, KEY,
        output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

endinterface

// File: rtl/project2_hex_to_7seg.sv
// hex_to_7seg: one nibble to an active-low seven-segment code.
// Ports: i_nib (4-bit value), o_seg (g..a, active-low).
import project2_pkg::*;

module hex_to_7seg (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/project2.sv
// project2: 24-bit hex calculator register on switches/buttons.
// Ports: CLOCK_50, FPGA_RESET_N, SW, KEY in; LEDR, HEX0..HEX5 out.
import project2_pkg::*;

module project2 (
    input  logic       CLOCK_50,
    input  logic       FPGA_RESET_N,
    input  logic [9:0] SW,
    input  logic [3:0] KEY,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    logic [23:0] r_v;
    logic        r_c;
    logic [3:0]  r_kp;

    logic [3:0]  w_press;
    logic [24:0] w_add;
    logic [24:0] w_sub;
    logic [23:0] w_v_nxt;
    logic        w_c_nxt;
    logic [6:0]  w_hex [NDIG];

    // Keys are active-low: a press is a 1 -> 0 step between edges.
    assign w_press = r_kp & ~KEY;

    // Bit 24 of the 25-bit add is the carry; of the subtract, the borrow.
    assign w_add = {1'b0, r_v} + {15'b0, SW};
    assign w_sub = {1'b0, r_v} - {15'b0, SW};

    always_comb begin
        w_v_nxt = r_v;
        w_c_nxt = r_c;
        priority case (1'b1)
            w_press[KEY_CLR]: begin
                w_v_nxt = '0;
                w_c_nxt = 1'b0;
            end
            w_press[KEY_DIGIT]: begin
                w_v_nxt = {r_v[19:0], SW[3:0]};
            end
            w_press[KEY_SUB]: begin
                w_v_nxt = w_sub[23:0];
                w_c_nxt = w_sub[24];
            end
            w_press[KEY_ADD]: begin
                w_v_nxt = w_add[23:0];
                w_c_nxt = w_add[24];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!FPGA_RESET_N) begin
            r_v  <= '0;
            r_c  <= 1'b0;
            r_kp <= 4'hF;
        end else begin
            r_v  <= w_v_nxt;
            r_c  <= w_c_nxt;
            r_kp <= KEY;
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        hex_to_7seg u_dig (
            .i_nib (r_v[4*g +: 4]),
            .o_seg (w_hex[g])
        );
    end

    assign HEX0 = w_hex[0];
    assign HEX1 = w_hex[1];
    assign HEX2 = w_hex[2];
    assign HEX3 = w_hex[3];
    assign HEX4 = w_hex[4];
    assign HEX5 = w_hex[5];

    assign LEDR = {(r_v == 24'h0), r_c, r_v[7:0]};

endmodule

// File: tb/tb_project2.sv
// tb_project2: scoreboard bench for the project2 hex calculator.
// Expected outputs are queued per driven cycle and popped after the edge.
module tb_project2;

    logic clk;
    logic rst_n;

    project2_if u_if ();

    project2 dut (
        .CLOCK_50     (clk),
        .FPGA_RESET_N (rst_n),
        .SW           (u_if.SW),
        .KEY          (u_if.KEY),
        .LEDR         (u_if.LEDR),
        .HEX0         (u_if.HEX0),
        .HEX1         (u_if.HEX1),
        .HEX2         (u_if.HEX2),
        .HEX3         (u_if.HEX3),
        .HEX4         (u_if.HEX4),
        .HEX5         (u_if.HEX5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [41:0] hex;
        logic [9:0]  ledr;
    } exp_t;

    exp_t q[$];

    int n_vec;
    int n_bad;

    logic [23:0] m_v;
    logic        m_c;
    logic [3:0]  m_kp;

    logic [6:0] tb_seg [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [41:0] ALL0 =
        {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [41:0] ALLF =
        {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E};

    function automatic logic [41:0] exp_hex(input logic [23:0] v);
        logic [41:0] r;
        for (int i = 0; i < 6; i++)
            r[7*i +: 7] = tb_seg[v[4*i +: 4]];
        return r;
    endfunction

    function automatic logic [41:0] dut_hex();
        return {u_if.HEX5, u_if.HEX4, u_if.HEX3,
                u_if.HEX2, u_if.HEX1, u_if.HEX0};
    endfunction

    task automatic chk(input string tag,
                       input logic [47:0] got,
                       input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference behaviour for one edge.
    task automatic model(input logic [3:0] key,
                         input logic [9:0] sw,
                         input logic rst);
        logic [3:0]  pr;
        logic [24:0] t;
        if (!rst) begin
            m_v  = '0;
            m_c  = 1'b0;
            m_kp = 4'hF;
        end else begin
            pr = m_kp & ~key;
            if (pr[3]) begin
                m_v = '0;
                m_c = 1'b0;
            end else if (pr[2]) begin
                m_v = {m_v[19:0], sw[3:0]};
            end else if (pr[1]) begin
                m_c = ({14'b0, sw} > m_v);
                m_v = m_v - {14'b0, sw};
            end else if (pr[0]) begin
                t   = m_v + {14'b0, sw};
                m_v = t[23:0];
                m_c = t[24];
            end
            m_kp = key;
        end
    endtask

    task automatic step(input logic [3:0] key,
                        input logic [9:0] sw,
                        input logic rst);
        exp_t e;
        @(negedge clk);
        u_if.KEY = key;
        u_if.SW  = sw;
        rst_n    = rst;
        model(key, sw, rst);
        e.hex  = exp_hex(m_v);
        e.ledr = {(m_v == 24'h0), m_c, m_v[7:0]};
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 48'd0, 48'd1);
        end else begin
            e = q.pop_front();
            chk("sb_hex",  {6'b0, dut_hex()}, {6'b0, e.hex});
            chk("sb_ledr", {38'b0, u_if.LEDR}, {38'b0, e.ledr});
        end
    endtask

    task automatic lit(input string tag,
                       input logic [41:0] hex,
                       input logic [9:0] ledr);
        chk({tag, "_hex"},  {6'b0, dut_hex()},  {6'b0, hex});
        chk({tag, "_ledr"}, {38'b0, u_if.LEDR}, {38'b0, ledr});
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        m_v      = '0;
        m_c      = 1'b0;
        m_kp     = 4'hF;
        rst_n    = 1'b0;
        u_if.KEY = 4'hF;
        u_if.SW  = '0;

        for (int i = 0; i < 8; i++) begin
            step(4'hF, 10'h0, 1'b0);
            lit("rst", ALL0, 10'h200);
        end

        step(4'hF, 10'h000, 1'b1);
        step(4'hF, 10'h3FF, 1'b1);
        step(4'hE, 10'h3FF, 1'b1);
        lit("add3ff",
            {7'h40, 7'h40, 7'h40, 7'h30, 7'h0E, 7'h0E}, 10'h0FF);
        step(4'hF, 10'h3FF, 1'b1);

        step(4'h7, 10'h0, 1'b1);
        step(4'hF, 10'h0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(4'hE, 10'h1, 1'b1);
        lit("hold", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}, 10'h001);
        step(4'hF, 10'h1, 1'b1);

        step(4'h7, 10'h0, 1'b1);
        step(4'hF, 10'h0, 1'b1);
        for (int d = 1; d <= 6; d++) begin
            step(4'hB, 10'(d), 1'b1);
            step(4'hF, 10'(d), 1'b1);
        end
        lit("digits",
            {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 10'h056);

        step(4'h7, 10'h0, 1'b1);
        step(4'hF, 10'h1, 1'b1);
        step(4'hD, 10'h1, 1'b1);
        lit("borrow", ALLF, 10'h1FF);
        step(4'hF, 10'h1, 1'b1);
        step(4'hE, 10'h1, 1'b1);
        lit("carry", ALL0, 10'h300);
        step(4'hF, 10'h1, 1'b1);

        step(4'hE, 10'h10, 1'b1);
        step(4'hF, 10'h10, 1'b1);
        lit("v10", {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40}, 10'h010);
        step(4'h6, 10'h1, 1'b1);
        lit("clrwins", ALL0, 10'h200);
        step(4'hF, 10'h1, 1'b1);

        step(4'hE, 10'h5, 1'b1);
        step(4'hF, 10'h5, 1'b1);
        step(4'hE, 10'h5, 1'b0);
        lit("rstpress", ALL0, 10'h200);
        step(4'hF, 10'h5, 1'b1);

        for (int i = 0; i < 60; i++)
            step(4'($urandom_range(0, 15)), 10'($urandom), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
